axis_delayline: RTL and testbench



---
 rtl/axis_delayline_pkg.sv | 18 +
 rtl/axis_delayline_if.sv | 28 ++
 rtl/axis_delayline_delay_ram.sv | 47 ++++
 rtl/axis_delayline.sv | 87 ++++++++
 tb/tb_axis_delayline.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_delayline_pkg.sv
// Shared parameters and sizing helpers for the
// beat-counted AXI4-Stream delay line.
package axis_delayline_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 64;

   // Pointer width; a single-entry line still needs one bit
   function automatic int ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Fill counter spans 0..depth inclusive
   function automatic int cnt_bits(input int depth);
      return (depth > 0) ? $clog2(depth + 1) : 1;
   endfunction

endpackage

// File: rtl/axis_delayline_if.sv
// AXI4-Stream link bundle with master and slave views.
// tready flows opposite to the payload.
interface axis_delayline_if
   import axis_delayline_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tlast;
   logic             tready;

   modport mst (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slv (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axis_delayline_delay_ram.sv
// delay_ram: single-port read-first synchronous RAM.
// A write returns the previous content of that address.
module axis_delayline_delay_ram
   import axis_delayline_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = ptr_bits(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   if (DEPTH == 1) begin : g_one
      logic [WIDTH-1:0] mem;
      logic             unused_addr;

      assign unused_addr = ^addr;

      // Single cell: read old value, then overwrite
      always_ff @(posedge clk) begin
         if (en) begin
            rdata <= mem;
            if (we) begin
               mem <= wdata;
            end
         end
      end
   end else begin : g_array
      logic [WIDTH-1:0] mem [DEPTH];

      // Read-first port: old data wins on same-address write
      always_ff @(posedge clk) begin
         if (en) begin
            rdata <= mem[addr];
            if (we) begin
               mem[addr] <= wdata;
            end
         end
      end
   end

endmodule

// File: rtl/axis_delayline.sv
// AXI4-Stream delay line: output beat n carries input
// beat n-DEPTH (zeros while filling); tlast is undelayed.
module axis_delayline
   import axis_delayline_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   axis_delayline_if.slv s,
   axis_delayline_if.mst m,
   output logic         primed
);

   localparam int PW = ptr_bits(DEPTH);
   localparam int CW = cnt_bits(DEPTH);

   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);

   if (DEPTH < 1) begin : g_bad_depth
      $error("axis_delayline: DEPTH must be at least 1");
   end

   if (WIDTH < 1) begin : g_bad_width
      $error("axis_delayline: WIDTH must be at least 1");
   end

   logic [PW-1:0]    wptr;
   logic [CW-1:0]    fcnt;
   logic             vld;
   logic             last;
   logic             use_ram;
   logic             accept;
   logic [WIDTH-1:0] rdata;

   assign primed   = (fcnt == FULL);
   assign s.tready = !vld || m.tready;
   assign accept   = s.tvalid && s.tready;

   assign m.tvalid = vld;
   assign m.tlast  = last;
   assign m.tdata  = use_ram ? rdata : '0;

   axis_delayline_delay_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_delay_ram (
      .clk   (clk),
      .en    (accept),
      .we    (accept),
      .addr  (wptr),
      .wdata (s.tdata),
      .rdata (rdata)
   );

   // Pointer wraps and fill level saturates per accepted beat
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         fcnt <= '0;
      end else if (accept) begin
         wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
         if (!primed) begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   // Output register: reload on accept, drain on handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         vld     <= 1'b0;
         last    <= 1'b0;
         use_ram <= 1'b0;
      end else if (accept) begin
         vld     <= 1'b1;
         last    <= s.tlast;
         use_ram <= primed;
      end else if (m.tready) begin
         vld     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_delayline.sv
// Bench for axis_delayline: DEPTH 4, 1 and 64 instances
// checked against a beat-index model every cycle.
module tb_axis_delayline;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [3];
   logic [15:0] sd  [3];
   logic        sv  [3];
   logic        sl  [3];
   logic        mr  [3];

   logic        rdy [3];
   logic        ov  [3];
   logic        ol  [3];
   logic [15:0] od  [3];
   logic        pm  [3];

   int dep [3] = '{4, 1, 64};

   int checks = 0;
   int errors = 0;

   int          acc  [3];
   int          outc [3];
   bit          started [3];
   logic [15:0] hd   [3][2048];
   logic        hl   [3][2048];
   logic [15:0] dlog [3][2048];
   logic        llog [3][2048];

   axis_delayline_if #(.WIDTH(16)) s0 ();
   axis_delayline_if #(.WIDTH(16)) m0 ();
   axis_delayline_if #(.WIDTH(16)) s1 ();
   axis_delayline_if #(.WIDTH(16)) m1 ();
   axis_delayline_if #(.WIDTH(16)) s2 ();
   axis_delayline_if #(.WIDTH(16)) m2 ();

   assign s0.tdata  = sd[0];
   assign s0.tvalid = sv[0];
   assign s0.tlast  = sl[0];
   assign m0.tready = mr[0];
   assign rdy[0]    = s0.tready;
   assign ov[0]     = m0.tvalid;
   assign od[0]     = m0.tdata;
   assign ol[0]     = m0.tlast;

   assign s1.tdata  = sd[1];
   assign s1.tvalid = sv[1];
   assign s1.tlast  = sl[1];
   assign m1.tready = mr[1];
   assign rdy[1]    = s1.tready;
   assign ov[1]     = m1.tvalid;
   assign od[1]     = m1.tdata;
   assign ol[1]     = m1.tlast;

   assign s2.tdata  = sd[2];
   assign s2.tvalid = sv[2];
   assign s2.tlast  = sl[2];
   assign m2.tready = mr[2];
   assign rdy[2]    = s2.tready;
   assign ov[2]     = m2.tvalid;
   assign od[2]     = m2.tdata;
   assign ol[2]     = m2.tlast;

   axis_delayline #(.WIDTH(16), .DEPTH(4)) dut4 (
      .clk    (clk),
      .rst    (rst[0]),
      .s      (s0),
      .m      (m0),
      .primed (pm[0])
   );

   axis_delayline #(.WIDTH(16), .DEPTH(1)) dut1 (
      .clk    (clk),
      .rst    (rst[1]),
      .s      (s1),
      .m      (m1),
      .primed (pm[1])
   );

   axis_delayline #(.WIDTH(16), .DEPTH(64)) dut64 (
      .clk    (clk),
      .rst    (rst[2]),
      .s      (s2),
      .m      (m2),
      .primed (pm[2])
   );

   task automatic chk(input string nm, input int d,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got=%h want=%h t=%0t",
                  nm, d, act, exp, $time);
      end
   endtask

   // Model: output n = input n-DEPTH (0 early), tlast of input n
   always @(negedge clk) begin
      int          pend;
      int          idx;
      logic        ev;
      logic [15:0] ed;
      logic        el;
      for (int d = 0; d < 3; d++) begin
         if (started[d]) begin
            pend = acc[d] - outc[d];
            chk("pending", d, 32'(pend <= 1 && pend >= 0), 1);
            ev = (pend != 0);
            chk("m_tvalid", d, ov[d], ev);
            if (ev) begin
               idx = outc[d];
               ed  = (idx < dep[d]) ? 16'h0 : hd[d][idx - dep[d]];
               el  = hl[d][idx];
               chk("m_tdata", d, od[d], ed);
               chk("m_tlast", d, ol[d], el);
            end
            chk("primed", d, pm[d], acc[d] >= dep[d]);
            chk("s_tready", d, rdy[d], !ev || mr[d]);
         end
         if (rst[d]) begin
            acc[d]     = 0;
            outc[d]    = 0;
            started[d] = 1'b1;
         end else if (started[d]) begin
            if (ov[d] && mr[d] && outc[d] < 2048) begin
               dlog[d][outc[d]] = od[d];
               llog[d][outc[d]] = ol[d];
               outc[d]++;
            end
            if (sv[d] && rdy[d] && acc[d] < 2048) begin
               hd[d][acc[d]] = sd[d];
               hl[d][acc[d]] = sl[d];
               acc[d]++;
            end
         end
      end
   end

   task automatic run(input int d, input int n,
                      input int base, input int pv,
                      input int pr, input int le,
                      output int cyc);
      int sent;
      sent = 0;
      cyc  = 0;
      while (sent < n && cyc < 20000) begin
         sv[d] = (int'($urandom_range(99)) < pv);
         sd[d] = 16'(base + sent);
         sl[d] = (le != 0) && (((sent + 1) % le) == 0);
         mr[d] = (int'($urandom_range(99)) < pr);
         @(negedge clk);
         if (sv[d] && rdy[d]) sent++;
         @(posedge clk);
         #1;
         cyc++;
      end
      sv[d] = 1'b0;
      sl[d] = 1'b0;
      chk("run_done", d, sent, n);
   endtask

   task automatic idle(input int d, input int k, input logic mrv);
      sv[d] = 1'b0;
      mr[d] = mrv;
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_rst(input int d);
      rst[d] = 1'b1;
      @(posedge clk);
      #1;
      rst[d] = 1'b0;
   endtask

   initial begin
      int c;
      for (int d = 0; d < 3; d++) begin
         rst[d]     = 1'b1;
         sv[d]      = 1'b0;
         sl[d]      = 1'b0;
         sd[d]      = '0;
         mr[d]      = 1'b1;
         started[d] = 1'b0;
         acc[d]     = 0;
         outc[d]    = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;

      @(negedge clk);
      chk("rst_valid", 0, ov[0], 0);
      chk("rst_data", 0, od[0], 0);
      chk("rst_last", 0, ol[0], 0);
      chk("rst_primed", 0, pm[0], 0);
      chk("rst_ready", 0, rdy[0], 1);
      @(posedge clk);
      #1;

      run(0, 16, 1, 100, 100, 8, c);
      chk("thru4_cycles", 0, c, 16);
      idle(0, 3, 1'b1);
      chk("d4_out0", 0, dlog[0][0], 16'h0);
      chk("d4_out3", 0, dlog[0][3], 16'h0);
      chk("d4_out4", 0, dlog[0][4], 16'h1);
      chk("d4_out11", 0, dlog[0][11], 16'h8);
      chk("d4_out15", 0, dlog[0][15], 16'hC);
      chk("d4_last6", 0, llog[0][6], 0);
      chk("d4_last7", 0, llog[0][7], 1);
      chk("d4_last15", 0, llog[0][15], 1);
      chk("d4_primed", 0, pm[0], 1);

      do_rst(0);
      run(0, 1000, 16'h200, 60, 50, 8, c);
      idle(0, 4, 1'b1);
      chk("rnd_count", 0, outc[0], 1000);
      chk("rnd_out4", 0, dlog[0][4], 16'h200);
      chk("rnd_out999", 0, dlog[0][999], 16'h200 + 995);

      do_rst(0);
      run(0, 10, 16'h30, 100, 100, 0, c);
      idle(0, 3, 1'b0);
      chk("stall_valid", 0, ov[0], 1);
      chk("stall_data", 0, od[0], 16'h35);
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      chk("mid_rst_valid", 0, ov[0], 0);
      chk("mid_rst_primed", 0, pm[0], 0);
      run(0, 8, 16'h50, 100, 100, 0, c);
      idle(0, 3, 1'b1);
      chk("post_out0", 0, dlog[0][0], 16'h0);
      chk("post_out3", 0, dlog[0][3], 16'h0);
      chk("post_out4", 0, dlog[0][4], 16'h50);
      chk("post_out7", 0, dlog[0][7], 16'h53);

      run(1, 3, 16'hA, 100, 100, 0, c);
      idle(1, 3, 1'b1);
      chk("d1_out0", 1, dlog[1][0], 16'h0);
      chk("d1_out1", 1, dlog[1][1], 16'hA);
      chk("d1_out2", 1, dlog[1][2], 16'hB);
      run(1, 200, 16'h300, 70, 50, 5, c);
      idle(1, 3, 1'b1);

      run(2, 200, 16'h100, 100, 100, 0, c);
      chk("thru64_cycles", 2, c, 200);
      idle(2, 3, 1'b1);
      chk("d64_out63", 2, dlog[2][63], 16'h0);
      chk("d64_out64", 2, dlog[2][64], 16'h100);
      chk("d64_out128", 2, dlog[2][128], 16'h140);
      chk("d64_out199", 2, dlog[2][199], 16'h100 + 135);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
